spi_sram_23lc512: RTL and testbench

- Synthesizable SPI-mode serial SRAM slave, command-compatible with the 23LC512 (64 KiB).
- Attaches to a host SPI master through user I/O pins.
- All SPI pins are oversampled by one system clock; no logic is clocked by SCK.
- Supports READ, WRITE, RDMR and WRMR in single-bit SPI mode 0, with byte, page and sequential addressing.

---
 rtl/spi_sram_23lc512.sv | 231 +++++++++++++++++++++++
 tb/tb_spi_sram_23lc512.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/spi_sram_23lc512.sv
`default_nettype none
//----------------------------------------------------------------------------
// spi_sram_23lc512 - 23LC512-compatible SPI mode-0 SRAM slave, pins oversampled by i_clock (rev 1.0)
//----------------------------------------------------------------------------
module spi_sram_23lc512 #(
  parameter int         ADDR_WIDTH   = 16,
  parameter int         PAGE_SIZE    = 32,
  parameter logic [7:0] MODE_DEFAULT = 8'h40
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_sck,
  input  logic i_cs_n,
  input  logic i_si,
  input  logic i_hold_n,
  output logic o_so,
  output logic o_so_oe
);

  localparam int                    c_depth     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_page_mask = ADDR_WIDTH'(PAGE_SIZE - 1);
  localparam logic [7:0]            c_cmd_read  = 8'h03;
  localparam logic [7:0]            c_cmd_write = 8'h02;
  localparam logic [7:0]            c_cmd_rdmr  = 8'h05;
  localparam logic [7:0]            c_cmd_wrmr  = 8'h01;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_RADDR, S_WADDR, S_RDATA, S_WDATA, S_RDMR, S_WRMR, S_IGNORE
  } state_t;

  logic r_sck_m, r_sck_s, r_sck_p;
  logic r_cs_m, r_cs_s, r_cs_p;
  logic r_si_m, r_si_s;
  logic r_hold_m, r_hold_s;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [14:0]           r_sr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_mode_hi;
  logic [7:0]            r_tx;
  logic [7:0]            r_wbyte;
  logic                  r_we;
  logic                  r_ld;
  logic                  r_ld_q;
  logic                  r_active;
  logic [7:0]            r_mem_q;
  logic [7:0]            r_mem [c_depth];

  logic                  w_bus_live;
  logic                  w_sck_rise;
  logic                  w_sck_fall;
  logic                  w_cs_rise;
  logic                  w_cs_fall;
  logic [15:0]           w_sr_next;
  logic [7:0]            w_mode;
  logic [ADDR_WIDTH-1:0] w_addr_inc;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [7:0]            w_tx;

  // Synchronizers keep sampling through reset so a cs_n held low across reset never looks like a new falling edge.
  always_ff @(posedge i_clock) begin
    r_sck_m  <= i_sck;    r_sck_s  <= r_sck_m;  r_sck_p <= r_sck_s;
    r_cs_m   <= i_cs_n;   r_cs_s   <= r_cs_m;   r_cs_p  <= r_cs_s;
    r_si_m   <= i_si;     r_si_s   <= r_si_m;
    r_hold_m <= i_hold_n; r_hold_s <= r_hold_m;
  end

  assign w_bus_live  = ~r_cs_s & r_hold_s;
  assign w_sck_rise  = r_sck_s & ~r_sck_p & w_bus_live;
  assign w_sck_fall  = ~r_sck_s & r_sck_p & w_bus_live;
  assign w_cs_rise   = r_cs_s & ~r_cs_p;
  assign w_cs_fall   = ~r_cs_s & r_cs_p;
  assign w_sr_next   = {r_sr, r_si_s};
  assign w_mode      = {r_mode_hi, 6'b000000};
  assign w_addr_inc  = r_addr + ADDR_WIDTH'(1);
  assign w_addr_next = (r_mode_hi == 2'b10) ? ((r_addr & ~c_page_mask) | (w_addr_inc & c_page_mask))
                                            : w_addr_inc;
  // A fall can land on the same clock the fetched byte arrives; take it straight from the RAM then.
  assign w_tx        = r_ld_q ? r_mem_q : r_tx;

  always_ff @(posedge i_clock) begin
    if (r_we) begin
      r_mem[r_addr] <= r_wbyte;
    end
    r_mem_q <= r_mem[r_addr];
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_sr      <= '0;
      r_addr    <= '0;
      r_mode_hi <= MODE_DEFAULT[7:6];
      r_tx      <= '0;
      r_wbyte   <= '0;
      r_we      <= 1'b0;
      r_ld      <= 1'b0;
      r_ld_q    <= 1'b0;
      r_active  <= 1'b0;
      o_so      <= 1'b0;
      o_so_oe   <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_ld   <= 1'b0;
      r_ld_q <= r_ld;
      // A completed write byte commits even if cs_n rises right after it.
      if (r_we) begin
        r_addr <= w_addr_next;
      end
      if (r_ld_q) begin
        r_tx <= r_mem_q;
      end
      if (w_cs_rise) begin
        r_state  <= S_IDLE;
        r_cnt    <= '0;
        r_active <= 1'b0;
        o_so_oe  <= 1'b0;
      end else if (!r_hold_s) begin
        o_so_oe <= 1'b0;
      end else begin
        o_so_oe <= r_active;
        case (r_state)
          S_IDLE: begin
            if (w_cs_fall) begin
              r_state  <= S_CMD;
              r_cnt    <= '0;
              r_active <= 1'b0;
            end
          end
          S_CMD: begin
            if (w_sck_rise) begin
              r_sr  <= w_sr_next[14:0];
              r_cnt <= r_cnt + 4'd1;
              if (r_cnt == 4'd7) begin
                r_cnt <= '0;
                case (w_sr_next[7:0])
                  c_cmd_read:  r_state <= S_RADDR;
                  c_cmd_write: r_state <= S_WADDR;
                  c_cmd_wrmr:  r_state <= S_WRMR;
                  c_cmd_rdmr: begin
                    r_state <= S_RDMR;
                    r_tx    <= w_mode;
                  end
                  default:     r_state <= S_IGNORE;
                endcase
              end
            end
          end
          S_RADDR, S_WADDR: begin
            if (w_sck_rise) begin
              r_sr  <= w_sr_next[14:0];
              r_cnt <= r_cnt + 4'd1;
              if (r_cnt == 4'd15) begin
                r_cnt   <= '0;
                r_addr  <= w_sr_next[ADDR_WIDTH-1:0];
                r_ld    <= (r_state == S_RADDR);
                r_state <= (r_state == S_RADDR) ? S_RDATA : S_WDATA;
              end
            end
          end
          S_RDATA: begin
            if (w_sck_fall) begin
              o_so     <= w_tx[7];
              r_tx     <= {w_tx[6:0], 1'b0};
              r_active <= 1'b1;
              o_so_oe  <= 1'b1;
            end else if (w_sck_rise) begin
              r_cnt <= r_cnt + 4'd1;
              if (r_cnt == 4'd7) begin
                r_cnt <= '0;
                if (r_mode_hi == 2'b00) begin
                  r_state  <= S_IGNORE;
                  r_active <= 1'b0;
                  o_so_oe  <= 1'b0;
                end else begin
                  r_addr <= w_addr_next;
                  r_ld   <= 1'b1;
                end
              end
            end
          end
          S_WDATA: begin
            if (w_sck_rise) begin
              r_sr  <= w_sr_next[14:0];
              r_cnt <= r_cnt + 4'd1;
              if (r_cnt == 4'd7) begin
                r_cnt   <= '0;
                r_wbyte <= w_sr_next[7:0];
                r_we    <= 1'b1;
                if (r_mode_hi == 2'b00) begin
                  r_state <= S_IGNORE;
                end
              end
            end
          end
          S_RDMR: begin
            if (w_sck_fall) begin
              o_so     <= r_tx[7];
              r_tx     <= {r_tx[6:0], r_tx[7]};
              r_active <= 1'b1;
              o_so_oe  <= 1'b1;
            end
          end
          S_WRMR: begin
            if (w_sck_rise) begin
              r_sr  <= w_sr_next[14:0];
              r_cnt <= r_cnt + 4'd1;
              if (r_cnt == 4'd7) begin
                r_cnt     <= '0;
                r_mode_hi <= w_sr_next[7:6];
                r_state   <= S_IGNORE;
              end
            end
          end
          S_IGNORE: begin
            r_active <= 1'b0;
            o_so_oe  <= 1'b0;
          end
          default: begin
            r_state  <= S_IDLE;
            r_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_sram_23lc512.sv
`default_nettype none
//----------------------------------------------------------------------------
// tb_spi_sram_23lc512 - table-driven bench for the SPI SRAM slave (rev 1.0)
//----------------------------------------------------------------------------
module tb_spi_sram_23lc512;

  logic r_clk = 1'b0;
  logic r_rst;
  logic r_sck;
  logic r_cs_n;
  logic r_si;
  logic r_hold_n;
  logic w_so;
  logic w_so_oe;

  int n_checks = 0;
  int n_pass   = 0;

  spi_sram_23lc512 #(
    .ADDR_WIDTH  (16),
    .PAGE_SIZE   (32),
    .MODE_DEFAULT(8'h40)
  ) u_dut (
    .i_clock (r_clk),
    .i_reset (r_rst),
    .i_sck   (r_sck),
    .i_cs_n  (r_cs_n),
    .i_si    (r_si),
    .i_hold_n(r_hold_n),
    .o_so    (w_so),
    .o_so_oe (w_so_oe)
  );

  always #5 r_clk = ~r_clk;

  typedef struct {
    string       name;
    logic [7:0]  cmd;
    logic        has_addr;
    logic [15:0] addr;
    int          nbytes;
    logic [23:0] wdata;
    logic [23:0] exp;
    logic [23:0] mask;
    logic [2:0]  exp_oe;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // SCK is 8 system clocks per period; so is sampled just before each rising edge.
  task automatic spi_bit(input logic b, output logic so_s, output logic oe_s);
    r_si = b;
    #40;
    so_s  = w_so;
    oe_s  = w_so_oe;
    r_sck = 1'b1;
    #40;
    r_sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx, output logic oe_and, output logic oe_or);
    logic s, e;
    oe_and = 1'b1;
    oe_or  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], s, e);
      rx[i]  = s;
      oe_and = oe_and & e;
      oe_or  = oe_or | e;
    end
  endtask

  task automatic run_txn(input logic [7:0] cmd, input logic has_addr, input logic [15:0] addr,
                         input int nbytes, input logic [23:0] wdata,
                         output logic [23:0] rx, output logic [2:0] oe_and, output logic [2:0] oe_or);
    logic [7:0] b;
    logic a, o;
    rx = '0; oe_and = '0; oe_or = '0;
    r_cs_n = 1'b0;
    #40;
    spi_byte(cmd, b, a, o);
    if (has_addr) begin
      spi_byte(addr[15:8], b, a, o);
      spi_byte(addr[7:0], b, a, o);
    end
    for (int k = 0; k < nbytes; k++) begin
      spi_byte(wdata[23-8*k -: 8], b, a, o);
      rx[23-8*k -: 8] = b;
      oe_and[2-k] = a;
      oe_or[2-k]  = o;
    end
    #40;
    r_cs_n = 1'b1;
    #80;
  endtask

  initial begin
    logic [23:0] rx;
    logic [2:0]  oa, oo, obs;
    logic [7:0]  b;
    logic        s, e, a, o;

    vecs[0]  = '{"rdmr_after_reset", 8'h05, 1'b0, 16'h0000, 2, 24'h000000, 24'h404000, 24'hFFFF00, 3'b110};
    vecs[1]  = '{"wr_1234",          8'h02, 1'b1, 16'h1234, 3, 24'hA45AC3, 24'h000000, 24'h000000, 3'b000};
    vecs[2]  = '{"rd_1234",          8'h03, 1'b1, 16'h1234, 3, 24'h000000, 24'hA45AC3, 24'hFFFFFF, 3'b111};
    vecs[3]  = '{"wr_0040",          8'h02, 1'b1, 16'h0040, 1, 24'hE70000, 24'h000000, 24'h000000, 3'b000};
    vecs[4]  = '{"wr_0011",          8'h02, 1'b1, 16'h0011, 1, 24'h990000, 24'h000000, 24'h000000, 3'b000};
    vecs[5]  = '{"wr_ffff_wrap",     8'h02, 1'b1, 16'hFFFF, 2, 24'h3CD200, 24'h000000, 24'h000000, 3'b000};
    vecs[6]  = '{"wr_0050",          8'h02, 1'b1, 16'h0050, 1, 24'hC90000, 24'h000000, 24'h000000, 3'b000};
    vecs[7]  = '{"rd_ffff_wrap",     8'h03, 1'b1, 16'hFFFF, 2, 24'h000000, 24'h3CD200, 24'hFFFF00, 3'b110};
    vecs[8]  = '{"wrmr_page",        8'h01, 1'b0, 16'h0000, 1, 24'h800000, 24'h000000, 24'h000000, 3'b000};
    vecs[9]  = '{"rdmr_page",        8'h05, 1'b0, 16'h0000, 2, 24'h000000, 24'h808000, 24'hFFFF00, 3'b110};
    vecs[10] = '{"wr_page_003e",     8'h02, 1'b1, 16'h003E, 3, 24'h112233, 24'h000000, 24'h000000, 3'b000};
    vecs[11] = '{"rd_page_003e",     8'h03, 1'b1, 16'h003E, 3, 24'h000000, 24'h112233, 24'hFFFFFF, 3'b111};
    vecs[12] = '{"wrmr_seq",         8'h01, 1'b0, 16'h0000, 1, 24'h400000, 24'h000000, 24'h000000, 3'b000};
    vecs[13] = '{"rd_seq_003f",      8'h03, 1'b1, 16'h003F, 2, 24'h000000, 24'h22E700, 24'hFFFF00, 3'b110};
    vecs[14] = '{"rd_0020",          8'h03, 1'b1, 16'h0020, 1, 24'h000000, 24'h330000, 24'hFF0000, 3'b100};
    vecs[15] = '{"wrmr_byte",        8'h01, 1'b0, 16'h0000, 1, 24'h000000, 24'h000000, 24'h000000, 3'b000};
    vecs[16] = '{"wr_byte_0010",     8'h02, 1'b1, 16'h0010, 2, 24'h778800, 24'h000000, 24'h000000, 3'b000};
    vecs[17] = '{"rd_byte_0010",     8'h03, 1'b1, 16'h0010, 2, 24'h000000, 24'h770000, 24'hFF0000, 3'b100};
    vecs[18] = '{"wrmr_seq2",        8'h01, 1'b0, 16'h0000, 1, 24'h400000, 24'h000000, 24'h000000, 3'b000};
    vecs[19] = '{"rd_seq_0010",      8'h03, 1'b1, 16'h0010, 2, 24'h000000, 24'h779900, 24'hFFFF00, 3'b110};
    vecs[20] = '{"unknown_ff",       8'hFF, 1'b0, 16'h0000, 2, 24'hFFFF00, 24'h000000, 24'h000000, 3'b000};
    vecs[21] = '{"rdmr_after_ff",    8'h05, 1'b0, 16'h0000, 2, 24'h000000, 24'h404000, 24'hFFFF00, 3'b110};

    r_rst = 1'b1; r_sck = 1'b0; r_cs_n = 1'b1; r_si = 1'b0; r_hold_n = 1'b1;
    repeat (6) @(posedge r_clk);
    #1 r_rst = 1'b0;
    #20;
    check("reset_so",    {23'b0, w_so},    24'h0);
    check("reset_so_oe", {23'b0, w_so_oe}, 24'h0);

    for (int v = 0; v < 22; v++) begin
      run_txn(vecs[v].cmd, vecs[v].has_addr, vecs[v].addr, vecs[v].nbytes, vecs[v].wdata, rx, oa, oo);
      if (vecs[v].mask != 24'h0) check({vecs[v].name, "_data"}, rx & vecs[v].mask, vecs[v].exp & vecs[v].mask);
      for (int j = 0; j < 3; j++) obs[j] = vecs[v].exp_oe[j] ? oa[j] : oo[j];
      check({vecs[v].name, "_oe"}, {21'b0, obs}, {21'b0, vecs[v].exp_oe});
    end

    // Partial write byte: 4 data bits then cs_n high must not touch 0x0050.
    r_cs_n = 1'b0; #40;
    spi_byte(8'h02, b, a, o); spi_byte(8'h00, b, a, o); spi_byte(8'h50, b, a, o);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, s, e);
    #40; r_cs_n = 1'b1; #80;
    run_txn(8'h03, 1'b1, 16'h0050, 1, 24'h0, rx, oa, oo);
    check("partial_write", rx & 24'hFF0000, 24'hC90000);

    // Partial WRMR: 4 bits of 8'h80 leave the mode register alone.
    r_cs_n = 1'b0; #40;
    spi_byte(8'h01, b, a, o);
    spi_bit(1'b1, s, e); spi_bit(1'b0, s, e); spi_bit(1'b0, s, e); spi_bit(1'b0, s, e);
    #40; r_cs_n = 1'b1; #80;
    run_txn(8'h05, 1'b0, 16'h0, 2, 24'h0, rx, oa, oo);
    check("partial_wrmr", rx & 24'hFFFF00, 24'h404000);

    // Hold mid-byte: so_oe drops, then the read resumes at the same bit.
    r_cs_n = 1'b0; #40;
    spi_byte(8'h03, b, a, o); spi_byte(8'h12, b, a, o); spi_byte(8'h34, b, a, o);
    rx = '0;
    for (int i = 7; i >= 4; i--) begin spi_bit(1'b0, s, e); rx[16+i] = s; end
    #40; r_hold_n = 1'b0; #100;
    check("hold_so_oe", {23'b0, w_so_oe}, 24'h0);
    r_hold_n = 1'b1; #40;
    for (int i = 3; i >= 0; i--) begin spi_bit(1'b0, s, e); rx[16+i] = s; end
    spi_byte(8'h00, b, a, o);
    rx[15:8] = b;
    #40; r_cs_n = 1'b1; #80;
    check("hold_resume_data", rx & 24'hFFFF00, 24'hA45A00);

    // Reset mid-READ with page mode set: oe drops, no restart without a new cs_n fall, mode back to 0x40.
    run_txn(8'h01, 1'b0, 16'h0, 1, 24'h800000, rx, oa, oo);
    r_cs_n = 1'b0; #40;
    spi_byte(8'h03, b, a, o); spi_byte(8'h12, b, a, o); spi_byte(8'h34, b, a, o);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, s, e);
    #40;
    @(posedge r_clk); #1 r_rst = 1'b1;
    repeat (3) @(posedge r_clk);
    #1 r_rst = 1'b0;
    #20;
    check("reset_mid_read_oe", {23'b0, w_so_oe}, 24'h0);
    spi_byte(8'h05, b, a, o);
    check("after_reset_no_restart_oe", {23'b0, o}, 24'h0);
    #40; r_cs_n = 1'b1; #80;
    run_txn(8'h05, 1'b0, 16'h0, 2, 24'h0, rx, oa, oo);
    check("mode_after_reset", rx & 24'hFFFF00, 24'h404000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
